// File: rtl/motor_relu_pkg.sv
// Shared widths and FSM state encoding for the motor ReLU layer sequencer.
// Both the sequencer top and its ReLU datapath use these definitions.
package motor_relu_pkg;

  localparam int DATA_W = 32;
  localparam int OUT_W  = DATA_W - 1;
  localparam int CNT_W  = 16;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_RUN   = 2'd1;
  localparam state_t S_DRAIN = 2'd2;
  localparam state_t S_DONE  = 2'd3;

endpackage

// File: rtl/motor_relu_unit.sv
// Combinational ReLU for ap_fixed two's complement samples: positive values pass
// with the sign bit dropped, zero and negatives (including the most negative) give 0.
module motor_relu_unit #(
  parameter int DATA_W = motor_relu_pkg::DATA_W,
  parameter int OUT_W  = motor_relu_pkg::OUT_W
) (
  input  logic signed [DATA_W-1:0] din,
  output logic        [OUT_W-1:0]  dout,
  output logic                     pos
);

  localparam logic signed [DATA_W-1:0] ZERO = '0;

  function automatic logic is_pos(input logic signed [DATA_W-1:0] x);
    return x > ZERO;
  endfunction

  function automatic logic [OUT_W-1:0] relu(input logic signed [DATA_W-1:0] x);
    logic [OUT_W-1:0] r;
    r = '0;
    if (is_pos(x)) r = x[OUT_W-1:0];
    return r;
  endfunction

  assign pos  = is_pos(din);
  assign dout = relu(din);

endmodule

// File: rtl/motor_relu_layer_seq.sv
// Sequencer that streams N_ELEM elements through the ReLU unit with a single
// output register, counting strictly positive elements per run.
module motor_relu_layer_seq #(
  parameter int N_ELEM = 16,
  parameter int DATA_W = motor_relu_pkg::DATA_W,
  parameter int OUT_W  = motor_relu_pkg::OUT_W
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     ap_start,
  output logic                     ap_idle,
  output logic                     ap_ready,
  output logic                     ap_done,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic        [OUT_W-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [15:0]       pos_count
);

  import motor_relu_pkg::*;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ELEM - 1);

  state_t           state;
  logic [CNT_W-1:0] elem_cnt;
  logic [CNT_W-1:0] pos_run;

  logic [OUT_W-1:0] relu_p0;
  logic             pos_p0;
  logic [OUT_W-1:0] data_p1;
  logic             vld_p1;

  logic in_hs;
  logic out_hs;

  // Stage p0: input sample through the combinational ReLU
  motor_relu_unit #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_relu (
    .din  (in_data),
    .dout (relu_p0),
    .pos  (pos_p0)
  );

  // The output slot can take a new element whenever it is empty or draining this cycle
  assign in_ready  = (state == S_RUN) && (!vld_p1 || out_ready);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = vld_p1 && out_ready;

  assign ap_idle   = (state == S_IDLE);
  assign ap_done   = (state == S_DONE);
  assign ap_ready  = (state == S_DONE);
  assign out_data  = data_p1;
  assign out_valid = vld_p1;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state     <= S_IDLE;
      elem_cnt  <= '0;
      pos_run   <= '0;
      pos_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            state    <= S_RUN;
            elem_cnt <= '0;
            pos_run  <= '0;
          end
        end
        S_RUN: begin
          if (in_hs) begin
            elem_cnt <= elem_cnt + 1'b1;
            if (pos_p0) pos_run <= pos_run + 1'b1;
            if (elem_cnt == LAST_IDX) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_hs) state <= S_DONE;
        end
        S_DONE: begin
          pos_count <= pos_run;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p1: output register; a simultaneous in/out handshake refills with no bubble
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (in_hs) begin
      vld_p1  <= 1'b1;
      data_p1 <= relu_p0;
    end else if (out_hs) begin
      vld_p1  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_motor_relu_layer_seq.sv
// Bench for motor_relu_layer_seq (N_ELEM=4): table vectors, hand sequences for
// backpressure/start/reset corners, and randomized runs against a ReLU model.
module tb_motor_relu_layer_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_idle;
  logic        ap_ready;
  logic        ap_done;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] pos_count;

  motor_relu_layer_seq #(.N_ELEM(4)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .ap_start  (ap_start),
    .ap_idle   (ap_idle),
    .ap_ready  (ap_ready),
    .ap_done   (ap_done),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pos_count (pos_count)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [31:0] din;
    logic [30:0] dout;
    logic        pos;
  } vec_t;

  vec_t        tbl[8];
  logic [31:0] stim[4];
  logic [30:0] exp_stim[4];
  int          exp_pos;
  logic [30:0] exp_q[$];

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  bit   seen_out;
  int   stall_left;
  bit   hold_pend = 1'b0;
  logic [30:0] hold_data = '0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference ReLU: value as a signed number, kept if above zero, sign bit dropped
  function automatic logic [30:0] relu_ref(input logic [31:0] v);
    longint x;
    x = longint'($signed(v));
    return (x > 0) ? 31'(x) : 31'd0;
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    case ($urandom_range(0, 6))
      0: w = 32'h8000_0000;
      1: w = 32'h0000_0000;
      2: w = 32'h0000_0001;
      3: w = 32'h7FFF_FFFF;
      4: w = 32'hFFFF_FFFF;
      default: w = $urandom();
    endcase
    return w;
  endfunction

  // Output monitor: ordering, hold-under-stall and in_ready gating
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      hold_pend = 1'b0;
    end else begin
      if (ap_done) done_cnt++;
      if (hold_pend) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(hold_data));
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (out_valid && !out_ready) check("in_ready_stall", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 32'(out_data), 32'hDEAD_BEEF);
        else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic upd_ready(input int mode);
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (!seen_out && out_valid) begin
          seen_out   = 1'b1;
          stall_left = 3;
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
  endtask

  // One layer run; called #1 after a rising edge, returns #1 after the edge leaving DONE
  task automatic run_layer(input int mode, input bit hold, input bit pulse,
                           input bit rnd_valid, output int lat);
    int idx, guard, first_hs, done_cyc, run_cyc, done0;
    bit hs, got_done;
    idx = 0; first_hs = -1; done_cyc = 0; run_cyc = 0; got_done = 1'b0;
    done0 = done_cnt; seen_out = 1'b0; stall_left = 0; out_ready = 1'b1;
    ap_start = 1'b1;
    guard = 0;
    do begin
      @(negedge ap_clk);
      guard++;
    end while (!ap_idle && guard < 50);
    check("idle_before_start", 32'(ap_idle), 32'd1);
    @(posedge ap_clk); #1;
    if (!hold) ap_start = 1'b0;
    in_data  = stim[0];
    in_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
    guard = 0;
    while (idx < 4 && guard < 300) begin
      @(negedge ap_clk);
      if (guard == 0) check("run_entered", 32'(ap_idle), 32'd0);
      hs = in_valid && in_ready;
      if (hs) begin
        exp_q.push_back(exp_stim[idx]);
        if (first_hs < 0) first_hs = cyc;
      end
      @(posedge ap_clk); #1;
      guard++;
      run_cyc++;
      if (hs) idx++;
      if (pulse) ap_start = (run_cyc >= 1 && run_cyc <= 3);
      in_valid = (idx < 4) && (rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (idx < 4) in_data = stim[idx];
      upd_ready(mode);
    end
    check("inputs_accepted", 32'(idx), 32'd4);
    in_valid = 1'b0;
    if (!hold) ap_start = 1'b0;
    guard = 0;
    while (!got_done && guard < 300) begin
      @(negedge ap_clk);
      if (ap_done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        check("ap_ready_pulse", 32'(ap_ready), 32'd1);
      end else begin
        @(posedge ap_clk); #1;
        upd_ready(mode);
      end
      guard++;
    end
    check("done_seen", 32'(got_done), 32'd1);
    lat = done_cyc - first_hs;
    @(posedge ap_clk); #1;
    check("done_one_cycle", 32'(ap_done), 32'd0);
    check("pos_count", 32'(pos_count), 32'(exp_pos));
    check("no_lost_dup", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_cnt - done0), 32'd1);
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int done0;

    tbl[0] = '{32'h0100_0000, 31'h0100_0000, 1'b1};
    tbl[1] = '{32'hFF00_0000, 31'h0000_0000, 1'b0};
    tbl[2] = '{32'h0000_0000, 31'h0000_0000, 1'b0};
    tbl[3] = '{32'h7FFF_FFFF, 31'h7FFF_FFFF, 1'b1};
    tbl[4] = '{32'h8000_0000, 31'h0000_0000, 1'b0};
    tbl[5] = '{32'h0000_0001, 31'h0000_0001, 1'b1};
    tbl[6] = '{32'hFFFF_FFFF, 31'h0000_0000, 1'b0};
    tbl[7] = '{32'h00AB_CDEF, 31'h00AB_CDEF, 1'b1};

    ap_rst = 1'b1; ap_start = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_idle", 32'(ap_idle), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_done", 32'(ap_done), 32'd0);
    check("rst_ready", 32'(ap_ready), 32'd0);
    check("rst_pos_count", 32'(pos_count), 32'd0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;

    // Table runs: streaming, then 3-cycle backpressure after the first output
    for (int r = 0; r < 2; r++) begin
      exp_pos = 0;
      for (int i = 0; i < 4; i++) begin
        stim[i]     = tbl[r*4 + i].din;
        exp_stim[i] = tbl[r*4 + i].dout;
        if (tbl[r*4 + i].pos) exp_pos++;
      end
      run_layer((r == 0) ? 0 : 2, 1'b0, 1'b0, 1'b0, lat);
      if (r == 0) check("stream_latency", 32'(lat), 32'd5);
    end

    // ap_start pulsed for 3 cycles mid-run must not cause a second run
    for (int i = 0; i < 4; i++) stim[i] = rnd_word();
    exp_pos = 0;
    for (int i = 0; i < 4; i++) begin
      exp_stim[i] = relu_ref(stim[i]);
      if ($signed(stim[i]) > 0) exp_pos++;
    end
    done0 = done_cnt;
    run_layer(0, 1'b0, 1'b1, 1'b0, lat);
    repeat (6) @(posedge ap_clk);
    #1;
    check("pulse_single_done", 32'(done_cnt - done0), 32'd1);
    check("pulse_back_idle", 32'(ap_idle), 32'd1);

    // ap_start held high: back-to-back runs with one IDLE cycle between
    for (int r = 0; r < 2; r++) begin
      exp_pos = 0;
      for (int i = 0; i < 4; i++) begin
        stim[i]     = rnd_word();
        exp_stim[i] = relu_ref(stim[i]);
        if ($signed(stim[i]) > 0) exp_pos++;
      end
      run_layer(0, 1'b1, 1'b0, 1'b0, lat);
      if (r == 0) check("held_idle_between", 32'(ap_idle), 32'd1);
    end
    ap_start = 1'b0;
    @(posedge ap_clk); #1;

    // Reset asserted after 2 of 4 elements
    done0 = done_cnt;
    stim[0] = 32'h0000_0010; stim[1] = 32'h0000_0020;
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_data = stim[k];
      @(negedge ap_clk);
      if (in_valid && in_ready) exp_q.push_back(relu_ref(stim[k]));
      @(posedge ap_clk); #1;
    end
    in_valid = 1'b0;
    check("mid_run_busy", 32'(ap_idle), 32'd0);
    check("mid_run_pending", 32'(out_valid), 32'd1);
    #2;
    ap_rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_idle", 32'(ap_idle), 32'd1);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_pos_count", 32'(pos_count), 32'd0);
    exp_q.delete();
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    repeat (6) @(posedge ap_clk);
    #1;
    check("abort_no_done", 32'(done_cnt - done0), 32'd0);
    check("abort_stay_idle", 32'(ap_idle), 32'd1);
    check("abort_pos_after", 32'(pos_count), 32'd0);

    // Randomized runs with input gaps and random output backpressure
    for (int r = 0; r < 8; r++) begin
      exp_pos = 0;
      for (int i = 0; i < 4; i++) begin
        stim[i]     = rnd_word();
        exp_stim[i] = relu_ref(stim[i]);
        if ($signed(stim[i]) > 0) exp_pos++;
      end
      run_layer(1, 1'b0, 1'b0, 1'b1, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
